code_lock_ctrl: RTL and testbench
=================================

Name: code_lock_ctrl

Overview:
- Parametrised keypad code-lock controller: digit entry, code programming, verification, failure counting and timed lockout, all in one registered FSM.
- Generalises the fixed 3-digit lock to N digits of W bits, with a configurable failure limit and a lockout period the previous generation lacked.
- Sits between the keypad scanner (keyboard_en/keyboard_num pulses) and the display/indicator logic.

Parameters:
- DIGITS, 3, code length in digits (1..8)
- DIGIT_W, 4, bits per digit
- MAX_FAIL, 3, consecutive failed verifications before lockout (1..15)
- LOCK_CYCLES, 1000, clk cycles spent in LOCKED
- DEFAULT_CODE, 0, stored code after reset (DIGITS*DIGIT_W bits)
- TIMEOUT_CYCLES, 5000, idle-entry timeout; used only with the optional feature

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- set_code_button  in  1  one-cycle pulse: begin programming a new code
- input_button  in  1  one-cycle pulse: begin entering a code for verification
- confirm_button  in  1  one-cycle pulse: finish the current entry
- keyboard_en  in  1  one-cycle pulse: keyboard_num is valid
- keyboard_num  in  DIGIT_W  key value
- password_input  out  DIGITS*DIGIT_W  entry buffer; newest digit in the LSBs
- input_count  out  clog2(DIGITS+1)  digits entered so far
- success_input  out  1  one-cycle pulse: new code stored
- match  out  1  level: last verification succeeded
- failure_times  out  clog2(MAX_FAIL+1)  consecutive failure count
- locked  out  1  high while in LOCKED
- current_work_state  out  3  FSM state encoding

Behaviour:
- All outputs are registered and update on the clk edge after the event (latency 1). An asynchronous reset clears all of them.
- Reset values:
  - state = IDLE; password_input = 0; input_count = 0.
  - success_input = 0; match = 0; failure_times = 0; locked = 0.
  - stored code = DEFAULT_CODE.
- State encoding: IDLE=0, SET=1, VERIFY=2, OPEN=3, LOCKED=4.
- IDLE and OPEN:
  - set_code_button -> SET; input_button -> VERIFY.
  - Either transition clears the buffer, input_count and match.
  - If both buttons pulse in the same cycle, set_code_button wins.
- SET and VERIFY, digit entry:
  - A keyboard_en pulse with input_count < DIGITS shifts the buffer left by DIGIT_W, inserts keyboard_num, and increments input_count.
  - keyboard_en is ignored when input_count == DIGITS (no wrap) and when keyboard_num > 9.
  - set_code_button or input_button arriving mid-entry restarts entry in the selected mode with the buffer cleared.
- Confirm priority: confirm_button takes priority over a keyboard_en in the same cycle, and that digit is dropped.
- SET + confirm:
  - input_count == DIGITS: store the buffer as the new code, pulse success_input, go to IDLE.
  - Otherwise: discard the entry, go to IDLE, stored code unchanged.
- VERIFY + confirm, match case: input_count == DIGITS and buffer == stored code -> match = 1, failure_times = 0, go to OPEN.
- VERIFY + confirm, failure case (any other outcome, including a short entry):
  - failure_times increments.
  - If it reaches MAX_FAIL, go to LOCKED, set locked = 1 and load the lockout counter. Otherwise go to IDLE.
- LOCKED:
  - All buttons and keys are ignored.
  - The counter decrements each cycle. When it reaches 0: failure_times = 0, locked = 0, buffer cleared, go to IDLE.
- confirm_button in IDLE, OPEN or LOCKED: no effect.
- match stays high in OPEN until the next set_code_button or input_button.
- Reset mid-entry or mid-lockout: immediate return to reset values; the stored code reverts to DEFAULT_CODE.

Optional Feature:
- Macro: CODE_LOCK_ENTRY_TIMEOUT_EN.
- When defined:
  - An idle counter runs in SET and VERIFY and reloads on every accepted digit or button.
  - After TIMEOUT_CYCLES cycles with no activity: buffer and count are cleared and the FSM returns to IDLE.
  - A timeout in VERIFY counts as a failure and may trigger LOCKED.
- When undefined: no counter is built, and entry waits indefinitely.

Decomposition:
- Shared package/header code_lock_pkg holds:
  - the state encoding localparams (IDLE..LOCKED);
  - the width helpers CODE_W = DIGITS*DIGIT_W and CNT_W;
  - the maximum valid digit constant (9).
- One sub-module, lock_timer: a loadable down-counter with a done pulse, instantiated for the lockout and, when the macro is defined, for the timeout.

Test Plan:
- Reset, then input_button, keys 0,0,0, confirm -> match = 1, state = 3 (OPEN), failure_times = 0.
- set_code_button, keys 4,2,7, confirm -> one-cycle success_input pulse.
  - Then verify with 4,2,7 -> match = 1.
  - Verify with 4,2,8 -> match = 0, failure_times = 1.
- Three wrong verifications (MAX_FAIL = 3, LOCK_CYCLES = 20):
  - locked = 1 and state = 4 for exactly 20 cycles, with keys ignored.
  - Then state = 0 and failure_times = 0.
- Four keys 1,2,3,4 entered (DIGITS = 3) -> buffer = 0x123, input_count = 3.
  - Key 0xA is ignored.
  - confirm in the same cycle as keyboard_en -> that digit is dropped.
- Short entry 1,2, then confirm in SET -> stored code unchanged, no success_input pulse.
  - Same short entry in VERIFY -> failure_times increments.
- With CODE_LOCK_ENTRY_TIMEOUT_EN and TIMEOUT_CYCLES = 10: input_button, one key, then 10 idle cycles -> state = 0, input_count = 0, failure_times = 1.

Source files
------------

// File: rtl/code_lock_pkg.sv
// Shared definitions for the keypad code-lock controller: state encoding,
// width helpers and the largest digit value the keypad may enter.
package code_lock_pkg;

    localparam logic [2:0] IDLE_ENC   = 3'd0;
    localparam logic [2:0] SET_ENC    = 3'd1;
    localparam logic [2:0] VERIFY_ENC = 3'd2;
    localparam logic [2:0] OPEN_ENC   = 3'd3;
    localparam logic [2:0] LOCKED_ENC = 3'd4;

    typedef enum logic [2:0] {
        IDLE   = IDLE_ENC,
        SET    = SET_ENC,
        VERIFY = VERIFY_ENC,
        OPEN   = OPEN_ENC,
        LOCKED = LOCKED_ENC
    } state_t;

    // Keys above this value are not digits and are never stored.
    localparam int MAX_DIGIT = 9;

    // Width of the full code / entry buffer.
    function automatic int code_w(input int digits, input int digit_w);
        return digits * digit_w;
    endfunction

    // Width of a counter that must be able to hold the value 'limit'.
    function automatic int cnt_w(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

endpackage

// File: rtl/lock_timer.sv
// Loadable down-counter. 'done' is high for the single cycle in which the
// counter sits at zero while enabled, so loading N-1 yields done N cycles
// after the load edge.
module lock_timer
    import code_lock_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             enable,
    input  logic [WIDTH-1:0] load_value,
    output logic             done
);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    // Load has priority; otherwise count down while enabled, parking at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_value;
        end else if (enable && (count_q != '0)) begin
            count_d = count_q - WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = enable && !load && (count_q == '0);

endmodule

// File: rtl/code_lock_ctrl.sv
// Keypad code-lock controller: digit entry, code programming, verification,
// consecutive-failure counting and a timed lockout. All outputs are registered.
// Optional feature: define CODE_LOCK_ENTRY_TIMEOUT_EN to abandon an entry
// after TIMEOUT_CYCLES cycles without activity in SET or VERIFY.
module code_lock_ctrl
    import code_lock_pkg::*;
#(
    parameter int DIGITS         = 3,
    parameter int DIGIT_W        = 4,
    parameter int MAX_FAIL       = 3,
    parameter int LOCK_CYCLES    = 1000,
    parameter logic [DIGITS*DIGIT_W-1:0] DEFAULT_CODE = '0,
    parameter int TIMEOUT_CYCLES = 5000
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic                                set_code_button,
    input  logic                                input_button,
    input  logic                                confirm_button,
    input  logic                                keyboard_en,
    input  logic [DIGIT_W-1:0]                  keyboard_num,
    output logic [code_w(DIGITS, DIGIT_W)-1:0]  password_input,
    output logic [cnt_w(DIGITS)-1:0]            input_count,
    output logic                                success_input,
    output logic                                match,
    output logic [cnt_w(MAX_FAIL)-1:0]          failure_times,
    output logic                                locked,
    output logic [2:0]                          current_work_state
);

    localparam int CODE_W = code_w(DIGITS, DIGIT_W);
    localparam int CNT_W  = cnt_w(DIGITS);
    localparam int FAIL_W = cnt_w(MAX_FAIL);
    localparam int LOCK_W = cnt_w(LOCK_CYCLES);

    localparam logic [CNT_W-1:0]  FULL_COUNT  = CNT_W'(DIGITS);
    localparam logic [FAIL_W-1:0] FAIL_LIMIT  = FAIL_W'(MAX_FAIL);
    localparam logic [LOCK_W-1:0] LOCK_RELOAD = LOCK_W'(LOCK_CYCLES - 1);

    state_t              state_q,   state_d;
    logic [CODE_W-1:0]   buf_q,     buf_d;
    logic [CNT_W-1:0]    count_q,   count_d;
    logic                success_q, success_d;
    logic                match_q,   match_d;
    logic [FAIL_W-1:0]   fail_q,    fail_d;
    logic                locked_q,  locked_d;
    logic [CODE_W-1:0]   code_q,    code_d;

    logic in_entry;
    logic digit_valid;
    logic key_accept;
    logic fail_event;
    logic lock_load;
    logic lock_done;

    assign in_entry    = (state_q == SET) || (state_q == VERIFY);
    assign digit_valid = (int'(keyboard_num) <= MAX_DIGIT);
    assign key_accept  = in_entry && keyboard_en && !set_code_button && !input_button &&
                         !confirm_button && (count_q != FULL_COUNT) && digit_valid;

`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
    localparam int ENTRY_W = cnt_w(TIMEOUT_CYCLES);
    localparam logic [ENTRY_W-1:0] ENTRY_RELOAD = ENTRY_W'(TIMEOUT_CYCLES - 1);

    logic entry_load;
    logic entry_timeout;

    // Any accepted digit or entry-starting button restarts the idle window.
    always_comb begin
        entry_load = key_accept || ((set_code_button || input_button) && (state_q != LOCKED));
    end

    lock_timer #(.WIDTH(ENTRY_W)) u_entry_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (entry_load),
        .enable     (in_entry),
        .load_value (ENTRY_RELOAD),
        .done       (entry_timeout)
    );
`endif

    lock_timer #(.WIDTH(LOCK_W)) u_lock_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (lock_load),
        .enable     (state_q == LOCKED),
        .load_value (LOCK_RELOAD),
        .done       (lock_done)
    );

    // Next-state and next-output logic for the whole controller.
    always_comb begin
        state_d    = state_q;
        buf_d      = buf_q;
        count_d    = count_q;
        success_d  = 1'b0;
        match_d    = match_q;
        fail_d     = fail_q;
        locked_d   = locked_q;
        code_d     = code_q;
        fail_event = 1'b0;
        lock_load  = 1'b0;

        unique case (state_q)
            IDLE, OPEN, SET, VERIFY: begin
                if (set_code_button || input_button) begin
                    state_d = set_code_button ? SET : VERIFY;
                    buf_d   = '0;
                    count_d = '0;
                    match_d = 1'b0;
                end else if (in_entry && confirm_button) begin
                    buf_d   = '0;
                    count_d = '0;
                    state_d = IDLE;
                    if (state_q == SET) begin
                        if (count_q == FULL_COUNT) begin
                            code_d    = buf_q;
                            success_d = 1'b1;
                        end
                    end else if ((count_q == FULL_COUNT) && (buf_q == code_q)) begin
                        match_d = 1'b1;
                        fail_d  = '0;
                        state_d = OPEN;
                    end else begin
                        fail_event = 1'b1;
                    end
                end else if (key_accept) begin
                    buf_d   = (buf_q << DIGIT_W) | CODE_W'(keyboard_num);
                    count_d = count_q + CNT_W'(1);
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
                end else if (entry_timeout) begin
                    buf_d      = '0;
                    count_d    = '0;
                    state_d    = IDLE;
                    fail_event = (state_q == VERIFY);
`endif
                end
            end
            LOCKED: begin
                if (lock_done) begin
                    fail_d   = '0;
                    locked_d = 1'b0;
                    buf_d    = '0;
                    count_d  = '0;
                    state_d  = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (fail_event) begin
            fail_d = fail_q + FAIL_W'(1);
            if (fail_d == FAIL_LIMIT) begin
                state_d   = LOCKED;
                locked_d  = 1'b1;
                lock_load = 1'b1;
            end
        end
    end

    // State, entry buffer, stored code and indicator registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            buf_q     <= '0;
            count_q   <= '0;
            success_q <= 1'b0;
            match_q   <= 1'b0;
            fail_q    <= '0;
            locked_q  <= 1'b0;
            code_q    <= DEFAULT_CODE;
        end else begin
            state_q   <= state_d;
            buf_q     <= buf_d;
            count_q   <= count_d;
            success_q <= success_d;
            match_q   <= match_d;
            fail_q    <= fail_d;
            locked_q  <= locked_d;
            code_q    <= code_d;
        end
    end

    assign password_input     = buf_q;
    assign input_count        = count_q;
    assign success_input      = success_q;
    assign match              = match_q;
    assign failure_times      = fail_q;
    assign locked             = locked_q;
    assign current_work_state = state_q;

endmodule

// File: tb/tb_code_lock_ctrl.sv
// Self-checking bench for code_lock_ctrl with a queue-based reference model.
module tb_code_lock_ctrl;

    localparam int DIGITS         = 3;
    localparam int DIGIT_W        = 4;
    localparam int MAX_FAIL       = 3;
    localparam int LOCK_CYCLES    = 20;
    localparam int TIMEOUT_CYCLES = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        set_code_button = 1'b0;
    logic        input_button = 1'b0;
    logic        confirm_button = 1'b0;
    logic        keyboard_en = 1'b0;
    logic [3:0]  keyboard_num = 4'd0;
    logic [11:0] password_input;
    logic [1:0]  input_count;
    logic        success_input;
    logic        match;
    logic [1:0]  failure_times;
    logic        locked;
    logic [2:0]  current_work_state;

    int errors = 0;
    int checks = 0;

    code_lock_ctrl #(
        .DIGITS         (DIGITS),
        .DIGIT_W        (DIGIT_W),
        .MAX_FAIL       (MAX_FAIL),
        .LOCK_CYCLES    (LOCK_CYCLES),
        .DEFAULT_CODE   (12'h000),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clk                (clk),
        .reset              (reset),
        .set_code_button    (set_code_button),
        .input_button       (input_button),
        .confirm_button     (confirm_button),
        .keyboard_en        (keyboard_en),
        .keyboard_num       (keyboard_num),
        .password_input     (password_input),
        .input_count        (input_count),
        .success_input      (success_input),
        .match              (match),
        .failure_times      (failure_times),
        .locked             (locked),
        .current_work_state (current_work_state)
    );

    always #5 clk = ~clk;

    // Reference model: 0 idle, 1 set, 2 verify, 3 open, 4 locked.
    int m_state;
    int m_entry[$];
    int m_code;
    int m_fail;
    bit m_match;
    bit m_locked;
    bit m_success;
    int m_lock_left;
    int m_idle;

    function automatic int entry_value();
        int v = 0;
        foreach (m_entry[j]) v = v * 16 + m_entry[j];
        return v;
    endfunction

    task automatic model_reset();
        m_state = 0; m_entry.delete(); m_code = 0; m_fail = 0;
        m_match = 0; m_locked = 0; m_success = 0; m_lock_left = 0; m_idle = 0;
    endtask

    task automatic model_fail();
        m_fail++;
        if (m_fail == MAX_FAIL) begin
            m_state = 4; m_locked = 1; m_lock_left = LOCK_CYCLES;
        end else begin
            m_state = 0;
        end
    endtask

    task automatic model_step(input bit s, input bit i, input bit c, input bit k, input int n);
        m_success = 0;
        case (m_state)
            0, 1, 2, 3: begin
                if (s || i) begin
                    m_state = s ? 1 : 2; m_entry.delete(); m_match = 0; m_idle = 0;
                end else if ((m_state == 1 || m_state == 2) && c) begin
                    if (m_state == 1) begin
                        if (m_entry.size() == DIGITS) begin m_code = entry_value(); m_success = 1; end
                        m_state = 0;
                    end else if (m_entry.size() == DIGITS && entry_value() == m_code) begin
                        m_match = 1; m_fail = 0; m_state = 3;
                    end else begin
                        model_fail();
                    end
                    m_entry.delete();
                end else if ((m_state == 1 || m_state == 2) && k && m_entry.size() < DIGITS && n <= 9) begin
                    m_entry.push_back(n); m_idle = 0;
                end else if (m_state == 1 || m_state == 2) begin
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
                    m_idle++;
                    if (m_idle == TIMEOUT_CYCLES) begin
                        m_entry.delete();
                        if (m_state == 2) model_fail(); else m_state = 0;
                    end
`endif
                end
            end
            4: begin
                m_lock_left--;
                if (m_lock_left == 0) begin
                    m_fail = 0; m_locked = 0; m_entry.delete(); m_state = 0;
                end
            end
            default: ;
        endcase
    endtask

    task automatic step(input bit s, input bit i, input bit c, input bit k, input int n);
        set_code_button = s; input_button = i; confirm_button = c;
        keyboard_en = k; keyboard_num = 4'(n);
        @(posedge clk);
        model_step(s, i, c, k, n);
        #1;
        set_code_button = 0; input_button = 0; confirm_button = 0;
        keyboard_en = 0; keyboard_num = 4'd0;
    endtask

    task automatic press(input int n);
        step(0, 0, 0, 1, n);
    endtask

    task automatic enter3(input bit is_set, input int a, input int b, input int c);
        step(is_set, !is_set, 0, 0, 0);
        press(a); press(b); press(c);
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_reset();
        #1 reset = 1;
        #2;
        model_reset();
        checks++; if (current_work_state !== 3'd0) begin errors++; $display("[TB] FAIL reset_state: got %0d want 0", current_work_state); end
        checks++; if (password_input !== 12'h0) begin errors++; $display("[TB] FAIL reset_buffer: got %0h want 0", password_input); end
        checks++; if (input_count !== 2'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d want 0", input_count); end
        checks++; if (success_input !== 1'b0) begin errors++; $display("[TB] FAIL reset_success: got %0b want 0", success_input); end
        checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL reset_match: got %0b want 0", match); end
        checks++; if (failure_times !== 2'd0) begin errors++; $display("[TB] FAIL reset_fail: got %0d want 0", failure_times); end
        checks++; if (locked !== 1'b0) begin errors++; $display("[TB] FAIL reset_locked: got %0b want 0", locked); end
        reset = 0;
        @(posedge clk); #1;
    endtask

    task automatic test_default_code();
        enter3(0, 0, 0, 0);
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL default_match: got %0b want 1", match); end
        checks++; if (current_work_state !== 3'd3) begin errors++; $display("[TB] FAIL default_state: got %0d want 3", current_work_state); end
        checks++; if (failure_times !== 2'd0) begin errors++; $display("[TB] FAIL default_fail: got %0d want 0", failure_times); end
    endtask

    task automatic test_program_code();
        enter3(1, 4, 2, 7);
        checks++; if (success_input !== 1'b1) begin errors++; $display("[TB] FAIL program_pulse: got %0b want 1", success_input); end
        step(0, 0, 0, 0, 0);
        checks++; if (success_input !== 1'b0) begin errors++; $display("[TB] FAIL program_pulse_end: got %0b want 0", success_input); end
        enter3(0, 4, 2, 7);
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL new_code_match: got %0b want 1", match); end
        enter3(0, 4, 2, 8);
        checks++; if (match !== 1'b0) begin errors++; $display("[TB] FAIL wrong_code_match: got %0b want 0", match); end
        checks++; if (failure_times !== 2'd1) begin errors++; $display("[TB] FAIL wrong_code_fail: got %0d want 1", failure_times); end
    endtask

    task automatic test_lockout();
        int lock_count;
        enter3(0, 4, 2, 7);
        for (int r = 0; r < MAX_FAIL; r++) enter3(0, 1, 1, 1);
        checks++; if (locked !== 1'b1 || current_work_state !== 3'd4) begin errors++; $display("[TB] FAIL lock_entry: got locked=%0b state=%0d want 1/4", locked, current_work_state); end
        lock_count = 1;
        for (int c = 0; c < 2 * LOCK_CYCLES; c++) begin
            step($urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0, 1, $urandom_range(0, 9));
            if (locked === 1'b1 && current_work_state === 3'd4) begin
                lock_count++;
                checks++; if (input_count !== 2'd0) begin errors++; $display("[TB] FAIL lock_keys_ignored: got count %0d want 0", input_count); end
            end else begin
                break;
            end
        end
        checks++; if (lock_count != LOCK_CYCLES) begin errors++; $display("[TB] FAIL lock_duration: got %0d want %0d", lock_count, LOCK_CYCLES); end
        checks++; if (current_work_state !== 3'd0 || failure_times !== 2'd0 || locked !== 1'b0) begin errors++; $display("[TB] FAIL lock_exit: got state=%0d fail=%0d locked=%0b want 0/0/0", current_work_state, failure_times, locked); end
    endtask

    task automatic test_entry_limits();
        step(1, 0, 0, 0, 0);
        press(1); press(2); press(3); press(4);
        checks++; if (password_input !== 12'h123 || input_count !== 2'd3) begin errors++; $display("[TB] FAIL full_entry: got %0h/%0d want 123/3", password_input, input_count); end
        press(10);
        checks++; if (password_input !== 12'h123) begin errors++; $display("[TB] FAIL key_a_full: got %0h want 123", password_input); end
        step(1, 0, 0, 0, 0);
        checks++; if (input_count !== 2'd0 || current_work_state !== 3'd1) begin errors++; $display("[TB] FAIL restart: got count %0d state %0d want 0/1", input_count, current_work_state); end
        press(1); press(10);
        checks++; if (password_input !== 12'h001 || input_count !== 2'd1) begin errors++; $display("[TB] FAIL key_a_ignored: got %0h/%0d want 1/1", password_input, input_count); end
        step(0, 0, 1, 0, 0);
        checks++; if (success_input !== 1'b0 || current_work_state !== 3'd0) begin errors++; $display("[TB] FAIL short_set: got success %0b state %0d want 0/0", success_input, current_work_state); end
        enter3(0, 4, 2, 7);
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL code_kept: got %0b want 1", match); end
        step(0, 1, 0, 0, 0);
        press(4); press(2);
        step(0, 0, 1, 1, 7);
        checks++; if (match !== 1'b0 || failure_times !== 2'd1) begin errors++; $display("[TB] FAIL confirm_drops_key: got match %0b fail %0d want 0/1", match, failure_times); end
    endtask

    task automatic test_short_verify();
        step(0, 1, 0, 0, 0);
        press(1); press(2);
        step(0, 0, 1, 0, 0);
        checks++; if (failure_times !== 2'd2 || current_work_state !== 3'd0) begin errors++; $display("[TB] FAIL short_verify: got fail %0d state %0d want 2/0", failure_times, current_work_state); end
        step(1, 1, 0, 0, 0);
        checks++; if (current_work_state !== 3'd1) begin errors++; $display("[TB] FAIL set_wins: got %0d want 1", current_work_state); end
        step(0, 0, 1, 0, 0);
    endtask

    task automatic test_random();
        for (int c = 0; c < 800; c++) begin
            step($urandom_range(0, 31) == 0, $urandom_range(0, 11) == 0, $urandom_range(0, 9) == 0,
                 $urandom_range(0, 1) == 1,
                 ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(0, 9)));
            checks++; if (current_work_state !== 3'(m_state)) begin errors++; $display("[TB] FAIL rnd_state c=%0d: got %0d want %0d", c, current_work_state, m_state); end
            checks++; if (password_input !== 12'(entry_value()) || input_count !== 2'(m_entry.size())) begin errors++; $display("[TB] FAIL rnd_entry c=%0d: got %0h/%0d want %0h/%0d", c, password_input, input_count, entry_value(), m_entry.size()); end
            checks++; if (failure_times !== 2'(m_fail) || locked !== m_locked) begin errors++; $display("[TB] FAIL rnd_fail c=%0d: got %0d/%0b want %0d/%0b", c, failure_times, locked, m_fail, m_locked); end
            checks++; if (match !== m_match || success_input !== m_success) begin errors++; $display("[TB] FAIL rnd_flags c=%0d: got %0b/%0b want %0b/%0b", c, match, success_input, m_match, m_success); end
        end
    endtask

    task automatic test_reset_mid();
        enter3(1, 9, 9, 9);
        step(0, 1, 0, 0, 0);
        press(9);
        #1 reset = 1;
        #2;
        model_reset();
        checks++; if (current_work_state !== 3'd0 || input_count !== 2'd0 || password_input !== 12'h0) begin errors++; $display("[TB] FAIL mid_reset: got %0d/%0d/%0h want 0/0/0", current_work_state, input_count, password_input); end
        reset = 0;
        @(posedge clk); #1;
        enter3(0, 0, 0, 0);
        checks++; if (match !== 1'b1) begin errors++; $display("[TB] FAIL code_reverted: got %0b want 1", match); end
    endtask

    task automatic test_timeout();
        step(0, 1, 0, 0, 0);
        press(5);
        for (int c = 0; c < TIMEOUT_CYCLES - 1; c++) step(0, 0, 0, 0, 0);
        checks++; if (current_work_state !== 3'd2) begin errors++; $display("[TB] FAIL timeout_early: got %0d want 2", current_work_state); end
`ifdef CODE_LOCK_ENTRY_TIMEOUT_EN
        step(0, 0, 0, 0, 0);
        checks++; if (current_work_state !== 3'd0 || input_count !== 2'd0 || failure_times !== 2'd1) begin errors++; $display("[TB] FAIL timeout: got %0d/%0d/%0d want 0/0/1", current_work_state, input_count, failure_times); end
`else
        for (int c = 0; c < 30; c++) step(0, 0, 0, 0, 0);
        checks++; if (current_work_state !== 3'd2 || input_count !== 2'd1) begin errors++; $display("[TB] FAIL no_timeout: got %0d/%0d want 2/1", current_work_state, input_count); end
        step(0, 0, 1, 0, 0);
`endif
    endtask

    initial begin
        $display("[TB] code_lock_ctrl bench start");
        test_reset();
        test_default_code();
        test_program_code();
        test_lockout();
        test_entry_limits();
        test_short_verify();
        test_random();
        test_reset_mid();
        test_timeout();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
